// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell plus a borrow
// flip-flop compute diff = a - b over WIDTH clocks, with a start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow_out hold the last result
// SHIFT | one operand bit pair consumed per clock, busy high
// DONE  | one-cycle done pulse; a new start is accepted here as in IDLE
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;

  logic             x, y, d_bit, br_nxt;
  logic [WIDTH:0]   res_cat;
  logic [WIDTH-1:0] res_shift;

  // Full-subtractor cell on the current LSBs; the new difference bit enters
  // the result register at the MSB so that after WIDTH shifts it is aligned.
  always_comb begin
    x         = a_sr_q[0];
    y         = b_sr_q[0];
    d_bit     = x ^ y ^ br_q;
    br_nxt    = (~x & y) | (~(x ^ y) & br_q);
    res_cat   = {d_bit, res_q} >> 1;
    res_shift = res_cat[WIDTH-1:0];
  end

  // Next-state and datapath update; start is honoured whenever not shifting.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    case (state_q)
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_shift;
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = res_shift;
          bo_d    = br_nxt;
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy       = (state_q == SHIFT);
    done       = (state_q == DONE);
    diff       = diff_q;
    borrow_out = bo_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 main instance plus a WIDTH=1
// instance for the single-bit corner.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrow_out;
  logic [7:0] diff;

  logic start1 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0;
  logic busy1, done1, bo1;
  logic diff1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  // Starts one op from a negedge with the DUT idle/done; returns at the
  // negedge where done is seen (or after the cycle budget expires).
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       output logic [7:0] d, output logic bo, output int busy_n,
                       output bit timeout, output bit early_chg, output bit overlap);
    logic [7:0] d0;
    d0 = diff; busy_n = 0; timeout = 1'b1; early_chg = 1'b0; overlap = 1'b0;
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin timeout = 1'b0; break; end
      if (busy) busy_n++;
      if (diff !== d0) early_chg = 1'b1;
      @(negedge clk);
    end
    d = diff; bo = borrow_out;
  endtask

  task automatic test_reset;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (diff !== 8'h00) begin miscompares++; $display("FAIL reset_diff got %h want 00", diff); end
    vectors++; if (borrow_out !== 1'b0) begin miscompares++; $display("FAIL reset_bo got %b want 0", borrow_out); end
    vectors++; if (busy1 !== 1'b0 || diff1 !== 1'b0 || bo1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_w1 got busy=%b diff=%b bo=%b want 0/0/0", busy1, diff1, bo1);
    end
  endtask

  task automatic test_directed;
    logic [7:0] va [6] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'hAA, 8'hFF};
    logic [7:0] vb [6] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'hAA, 8'h00};
    logic [7:0] ed [6] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h00, 8'hFF};
    logic       eb [6] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    logic [7:0] d; logic bo; int bn; bit to, ec, ov;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], d, bo, bn, to, ec, ov);
      vectors++; if (to) begin miscompares++; $display("FAIL dir%0d_timeout no done within budget", i); end
      vectors++; if (d !== ed[i]) begin miscompares++; $display("FAIL dir%0d_diff got %h want %h", i, d, ed[i]); end
      vectors++; if (bo !== eb[i]) begin miscompares++; $display("FAIL dir%0d_bo got %b want %b", i, bo, eb[i]); end
      vectors++; if (bn != 8) begin miscompares++; $display("FAIL dir%0d_busy_cycles got %0d want 8", i, bn); end
      vectors++; if (ec || ov) begin miscompares++; $display("FAIL dir%0d_stability early_change=%0d busy_done_overlap=%0d want 0/0", i, ec, ov); end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL dir%0d_done_width got %b want 0", i, done); end
    end
  endtask

  task automatic test_start_held;
    bit seen; int bn;
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'h55; b = 8'h22;
    seen = 1'b0; bn = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bn++;
      if (bn == 6) start = 1'b0;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL held_timeout no done within budget"); end
    vectors++; if (diff !== 8'h0F || borrow_out !== 1'b0) begin
      miscompares++; $display("FAIL held_result got %h/%b want 0f/0", diff, borrow_out);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] d; logic bo; int bn; bit to, ec, ov; int gap; bit seen;
    do_op(8'h20, 8'h30, d, bo, bn, to, ec, ov);
    vectors++; if (to || d !== 8'hF0 || bo !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first got %h/%b timeout=%0d want f0/1/0", d, bo, to);
    end
    a = 8'h09; b = 8'h0A; start = 1'b1;
    @(negedge clk);
    start = 1'b0; gap = 1; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk); gap++;
    end
    vectors++; if (!seen || gap != 9) begin
      miscompares++; $display("FAIL b2b_gap got %0d seen=%0d want 9", gap, seen);
    end
    vectors++; if (diff !== 8'hFF || borrow_out !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second got %h/%b want ff/1", diff, borrow_out);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] d; logic bo; int bn; bit to, ec, ov; bit saw_done;
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      miscompares++; $display("FAIL mid_abort got busy=%b diff=%h bo=%b want 0/00/0", busy, diff, borrow_out);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    vectors++; if (saw_done) begin miscompares++; $display("FAIL mid_no_done got activity after abort want none"); end
    do_op(8'h05, 8'h03, d, bo, bn, to, ec, ov);
    vectors++; if (to || d !== 8'h02 || bo !== 1'b0 || bn != 8) begin
      miscompares++; $display("FAIL mid_recover got %h/%b busy=%0d timeout=%0d want 02/0/8/0", d, bo, bn, to);
    end
    @(negedge clk);
  endtask

  task automatic test_width1;
    logic ea [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic eb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int bn; bit seen;
    for (int i = 0; i < 4; i++) begin
      a1 = ea[i]; b1 = eb[i]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; bn = 0; seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (done1) begin seen = 1'b1; break; end
        if (busy1) bn++;
        @(negedge clk);
      end
      vectors++; if (!seen || diff1 !== ed[i] || bo1 !== eo[i] || bn != 1) begin
        miscompares++;
        $display("FAIL w1_%0d got diff=%b bo=%b busy=%0d seen=%0d want %b/%b/1/1", i, diff1, bo1, bn, seen, ed[i], eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    logic [7:0] d; logic bo; int bn; bit to, ec, ov; logic [7:0] ra, rb, ed; logic eb;
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      ed = ra - rb; eb = (ra < rb);
      do_op(ra, rb, d, bo, bn, to, ec, ov);
      vectors++;
      if (to || d !== ed || bo !== eb || bn != 8 || ov) begin
        miscompares++; bad++;
        if (bad < 10) $display("FAIL rnd a=%h b=%h got %h/%b busy=%0d want %h/%b/8", ra, rb, d, bo, bn, ed, eb);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_directed;
    test_start_held;
    test_back_to_back;
    test_reset_mid;
    test_width1;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
